// File: rtl/bcd_to_binary_seq.sv
// Sequential 8-digit packed BCD to binary converter (reverse double dabble).
// One shift/correct iteration per clock, start/busy/done handshake, malformed-digit flag.

module bcd_digit_fix (
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       bad
);
  assign dout = (din >= 4'd8) ? din - 4'd3 : din;
  assign bad  = (din > 4'd9);
endmodule

module bcd_to_binary_seq #(
  parameter int DIGITS    = 8,
  parameter int BIN_WIDTH = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid,
  output logic [BIN_WIDTH-1:0]  binary_out
);
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;

  logic [0:0]             state;
  logic [4*DIGITS-1:0]    bcd_sh;
  logic [BIN_WIDTH-1:0]   bin_sh;
  logic [CW-1:0]          cnt;

  logic [4*DIGITS-1:0]          bcd_shift;
  logic [DIGITS-1:0][3:0]       bcd_shift_d;
  logic [DIGITS-1:0][3:0]       bcd_fix_d;
  logic [DIGITS-1:0][3:0]       in_d;
  logic [DIGITS-1:0][3:0]       in_unused;
  logic [DIGITS-1:0]            in_bad;
  logic [DIGITS-1:0]            shift_bad_unused;
  logic [BIN_WIDTH-1:0]         bin_next;
  logic                         any_bad;

  assign bcd_shift   = {1'b0, bcd_sh[4*DIGITS-1:1]};
  assign bcd_shift_d = bcd_shift;
  assign in_d        = bcd_in;
  assign bin_next    = {bcd_sh[0], bin_sh[BIN_WIDTH-1:1]};
  assign any_bad     = |in_bad;

  // Each digit gets one unit correcting the shifted register and one validating the request.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_fix u_fix (
        .din  (bcd_shift_d[g]),
        .dout (bcd_fix_d[g]),
        .bad  (shift_bad_unused[g])
      );
      bcd_digit_fix u_chk (
        .din  (in_d[g]),
        .dout (in_unused[g]),
        .bad  (in_bad[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      invalid    <= 1'b0;
      binary_out <= '0;
      bcd_sh     <= '0;
      bin_sh     <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (any_bad) begin
              done       <= 1'b1;
              invalid    <= 1'b1;
              binary_out <= '0;
            end else begin
              bcd_sh <= bcd_in;
              bin_sh <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= CONVERT;
            end
          end
        end
        CONVERT: begin
          bcd_sh <= bcd_fix_d;
          bin_sh <= bin_next;
          cnt    <= cnt + CW'(1);
          // Last shift: the result is the freshly shifted bin_sh, not the stale register.
          if (cnt == LAST) begin
            binary_out <= bin_next;
            invalid    <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: latency, results, invalid digits,
// start-while-busy, back-to-back held start and mid-conversion reset.

module tb_bcd_to_binary_seq;
  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] bcd_in;
  logic        busy;
  logic        done;
  logic        invalid;
  logic [26:0] binary_out;

  int checks = 0;
  int errors = 0;

  bcd_to_binary_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .done       (done),
    .invalid    (invalid),
    .binary_out (binary_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its done pulse.
  task automatic run(input string tag, input logic [31:0] bcd,
                     input logic [26:0] exp_bin, input logic exp_inv);
    int n;
    int bc;
    n  = 0;
    bc = 0;
    bcd_in = bcd;
    start  = 1'b1;
    step();
    start  = 1'b0;
    bcd_in = 32'hFFFF_FFFF;
    while (!done && n < 40) begin
      if (busy) bc++;
      step();
      n++;
    end
    chk({tag, "_latency"}, n, exp_inv ? 0 : 27);
    chk({tag, "_busy_cycles"}, bc, exp_inv ? 0 : 27);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    chk({tag, "_invalid"}, {31'd0, invalid}, {31'd0, exp_inv});
    chk({tag, "_bin"}, {5'd0, binary_out}, {5'd0, exp_bin});
    if (!exp_inv) chk({tag, "_bcd_sh_zero"}, dut.bcd_sh, 0);
    step();
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 0);
  endtask

  initial begin
    int nd;
    int last_c;
    int first_c;
    logic [26:0] val;

    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_invalid", {31'd0, invalid}, 0);
    chk("rst_bin", {5'd0, binary_out}, 0);
    reset = 1'b0;
    step();

    run("zero",   32'h0000_0000, 27'd0,         1'b0);
    run("mid",    32'h1234_5678, 27'h0BC_614E,  1'b0);
    run("max",    32'h9999_9999, 27'h5F5_E0FF,  1'b0);
    run("bad_lo", 32'h0000_000A, 27'd0,         1'b1);
    run("bad_hi", 32'hF000_0000, 27'd0,         1'b1);
    run("after",  32'h0000_0042, 27'd42,        1'b0);

    // Outputs hold while idle with start low.
    repeat (5) step();
    chk("idle_hold_bin", {5'd0, binary_out}, 42);
    chk("idle_hold_done", {31'd0, done}, 0);

    // A second start while busy must be ignored.
    bcd_in = 32'h0000_0100;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (9) step();
    bcd_in = 32'h0000_0999;
    start  = 1'b1;
    step();
    start  = 1'b0;
    nd  = 0;
    val = '0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        nd++;
        val = binary_out;
      end
      step();
    end
    chk("busy_ign_count", nd, 1);
    chk("busy_ign_bin", {5'd0, val}, 100);

    // Start held high: one result every 28 cycles.
    bcd_in = 32'h0000_0255;
    start  = 1'b1;
    step();
    nd      = 0;
    last_c  = 0;
    first_c = 0;
    for (int c = 1; c <= 90; c++) begin
      step();
      if (done) begin
        nd++;
        chk("held_bin", {5'd0, binary_out}, 255);
        chk("held_busy_low", {31'd0, busy}, 0);
        if (nd == 1) first_c = c;
        else chk("held_gap", c - last_c, 28);
        last_c = c;
      end
    end
    chk("held_count", nd, 3);
    chk("held_first", first_c, 27);
    start = 1'b0;
    nd = 0;
    while (!done && nd < 40) begin
      step();
      nd++;
    end
    chk("held_drain", {31'd0, done}, 1);
    step();

    // Reset mid-conversion abandons the work.
    bcd_in = 32'h8765_4321;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (12) step();
    chk("pre_rst_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_bin", {5'd0, binary_out}, 0);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) nd++;
      step();
    end
    chk("mid_rst_no_done", nd, 0);
    run("after_rst", 32'h8765_4321, 27'h539_7FB1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
